ext_irq_ctrl: RTL and testbench

Board-level external interrupt controller converting the raw, bouncing BTNC push-button into a single clean interrupt request for the RISC-V core. It synchronises and debounces the button, detects press (rising) events, holds a level interrupt until the core acknowledges it, flags events lost while an interrupt was outstanding, and keeps a wrapping press counter for display on LED.

---
 rtl/ext_irq_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 108 ++++++++++
 rtl/ext_irq_ctrl.sv | 79 +++++++
 tb/tb_ext_irq_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_irq_pkg.sv
// ============================================================================
// Module  : ext_irq_pkg
// Brief   : Shared debounce state encoding and defaults for ext_irq_ctrl.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package ext_irq_pkg;

    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] CHK_HI    = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] CHK_LO    = 2'd3;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module  : btn_debounce
// Brief   : Button synchroniser, debounce FSM and one-cycle rise indication.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import ext_irq_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int               CNT_BITS = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // The candidate level is counted from the first differing sample, so a
    // change is accepted after DEBOUNCE_CYCLES consecutive agreeing samples.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_i};
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise    = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Decoded from flops only, so the consumer updates on the same edge as level_q.
    assign level_o = level_q;
    assign rise_o  = rise;

endmodule

`default_nettype wire

// File: rtl/ext_irq_ctrl.sv
// ============================================================================
// Module  : ext_irq_ctrl
// Brief   : BTNC external interrupt controller: debounced press -> level IRQ.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module ext_irq_ctrl
    import ext_irq_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             btn_i,
    input  logic             ack_i,
    output logic             irq_o,
    output logic             missed_o,
    output logic             btn_level_o,
    output logic [CNT_W-1:0] event_cnt_o
);

    logic             press;
    logic             irq_q, irq_d;
    logic             missed_q, missed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (CLK100MHZ),
        .rst_n  (CPU_RESETN),
        .btn_i  (btn_i),
        .level_o(btn_level_o),
        .rise_o (press)
    );

    // A press coinciding with an ack re-arms the request instead of losing it.
    always_comb begin
        irq_d    = irq_q;
        missed_d = missed_q;
        cnt_d    = cnt_q;
        if (press) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (!irq_q) begin
                irq_d = 1'b1;
            end else if (ack_i) begin
                missed_d = 1'b0;
            end else begin
                missed_d = 1'b1;
            end
        end else if (ack_i && irq_q) begin
            irq_d    = 1'b0;
            missed_d = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            irq_q    <= 1'b0;
            missed_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            irq_q    <= irq_d;
            missed_q <= missed_d;
            cnt_q    <= cnt_d;
        end
    end

    assign irq_o       = irq_q;
    assign missed_o    = missed_q;
    assign event_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ext_irq_ctrl.sv
// ============================================================================
// Module  : tb_ext_irq_ctrl
// Brief   : Self-checking bench for ext_irq_ctrl (scenario table + random model).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ext_irq_ctrl;

    localparam int SYNC    = 2;
    localparam int DEB     = 8;
    localparam int CNT_W   = 16;
    localparam int CNT_W_S = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btn   = 1'b0;
    logic ack   = 1'b0;

    logic               irq, missed, lvl;
    logic [CNT_W-1:0]   cnt;
    logic               irq_s, missed_s, lvl_s;
    logic [CNT_W_S-1:0] cnt_s;

    int n_checks = 0;
    int n_errors = 0;
    bit live_chk = 1'b0;

    always #5 clk = ~clk;

    ext_irq_ctrl #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .btn_i(btn), .ack_i(ack),
        .irq_o(irq), .missed_o(missed), .btn_level_o(lvl), .event_cnt_o(cnt)
    );

    ext_irq_ctrl #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W_S)) dut_w (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .btn_i(btn), .ack_i(ack),
        .irq_o(irq_s), .missed_o(missed_s), .btn_level_o(lvl_s), .event_cnt_o(cnt_s)
    );

    // Reference: s is btn delayed SYNC cycles; a level change is accepted once
    // s has disagreed with the current level for DEB consecutive cycles.
    typedef struct {
        logic [SYNC-1:0] sync;
        int              run;
        bit              lvl;
        bit              irq;
        bit              missed;
        int unsigned     cnt;
    } model_t;

    model_t m;

    function automatic model_t step(model_t cur, logic b, logic a);
        model_t n;
        logic   s;
        bit     press;
        n      = cur;
        s      = cur.sync[SYNC-1];
        n.sync = {cur.sync[SYNC-2:0], b};
        press  = 1'b0;
        if (s != cur.lvl) begin
            n.run = cur.run + 1;
            if (n.run == DEB) begin
                n.lvl = s;
                n.run = 0;
                press = s;
            end
        end else begin
            n.run = 0;
        end
        if (press) begin
            n.cnt = cur.cnt + 1;
            if (!cur.irq)  n.irq = 1'b1;
            else if (a)    n.missed = 1'b0;
            else           n.missed = 1'b1;
        end else if (a && cur.irq) begin
            n.irq    = 1'b0;
            n.missed = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{sync: '0, run: 0, lvl: 1'b0, irq: 1'b0, missed: 1'b0, cnt: 0};
        else        m <= step(m, btn, ack);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && live_chk) begin
            check("model_irq",    32'(irq),    32'(m.irq));
            check("model_missed", 32'(missed), 32'(m.missed));
            check("model_level",  32'(lvl),    32'(m.lvl));
            check("model_cnt",    32'(cnt),    m.cnt % (1 << CNT_W));
            check("model_cnt_w",  32'(cnt_s),  m.cnt % (1 << CNT_W_S));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_irq"},    32'(irq),    0);
        check({name, "_missed"}, 32'(missed), 0);
        check({name, "_level"},  32'(lvl),    0);
        check({name, "_cnt"},    32'(cnt),    0);
    endtask

    task automatic do_reset(input logic btn_val);
        @(negedge clk);
        #1 rst_n = 1'b0;
        btn = btn_val;
        ack = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Button rises just before edge 1; level must appear exactly at edge SYNC+DEB.
    task automatic press(input bit ack_co);
        btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == SYNC + DEB - 2) begin
                check("press_level_early", 32'(lvl), 0);
                if (ack_co) ack = 1'b1;
            end
            if (i == SYNC + DEB - 1) begin
                check("press_level_on", 32'(lvl), 1);
                check("press_irq_on",   32'(irq), 1);
                ack = 1'b0;
            end
        end
        btn = 1'b0;
        idle(20);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        idle(1);
        ack = 1'b0;
        check("ack_clears_irq", 32'(irq), 0);
    endtask

    typedef struct {
        int presses;
        bit bounce;
        bit ack_after;
        bit ack_last;
        bit e_irq;
        bit e_missed;
        int e_cnt;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{presses: 0, bounce: 0, ack_after: 0, ack_last: 0, e_irq: 0, e_missed: 0, e_cnt: 0};
        tbl[1] = '{presses: 1, bounce: 0, ack_after: 0, ack_last: 0, e_irq: 1, e_missed: 0, e_cnt: 1};
        tbl[2] = '{presses: 1, bounce: 0, ack_after: 1, ack_last: 0, e_irq: 0, e_missed: 0, e_cnt: 1};
        tbl[3] = '{presses: 0, bounce: 1, ack_after: 0, ack_last: 0, e_irq: 0, e_missed: 0, e_cnt: 0};
        tbl[4] = '{presses: 2, bounce: 0, ack_after: 0, ack_last: 0, e_irq: 1, e_missed: 1, e_cnt: 2};
        tbl[5] = '{presses: 2, bounce: 0, ack_after: 1, ack_last: 0, e_irq: 0, e_missed: 0, e_cnt: 2};
        tbl[6] = '{presses: 2, bounce: 0, ack_after: 0, ack_last: 1, e_irq: 1, e_missed: 0, e_cnt: 2};

        repeat (2) @(negedge clk);
        live_chk = 1'b1;

        for (int v = 0; v < 7; v++) begin
            do_reset(1'b0);
            idle(50);
            if (tbl[v].bounce) begin
                repeat (3) begin
                    btn = 1'b1; idle(4);
                    btn = 1'b0; idle(4);
                end
                idle(20);
            end
            for (int p = 0; p < tbl[v].presses; p++)
                press(tbl[v].ack_last && (p == tbl[v].presses - 1));
            if (tbl[v].ack_after) do_ack();
            check($sformatf("vec%0d_irq", v),    32'(irq),    32'(tbl[v].e_irq));
            check($sformatf("vec%0d_missed", v), 32'(missed), 32'(tbl[v].e_missed));
            check($sformatf("vec%0d_level", v),  32'(lvl),    0);
            check($sformatf("vec%0d_cnt", v),    32'(cnt),    32'(tbl[v].e_cnt));
        end

        // Reset asserted while the high level is still being qualified.
        do_reset(1'b0);
        btn = 1'b1;
        idle(SYNC + 5);
        #1 rst_n = 1'b0;
        btn = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("midcount_rst");
        #1 rst_n = 1'b1;
        @(negedge clk);
        idle(30);
        check_zero("midcount_after");

        // Button held across reset release counts as one fresh press.
        do_reset(1'b1);
        idle(SYNC + DEB + 2);
        check("held_level", 32'(lvl), 1);
        check("held_irq",   32'(irq), 1);
        check("held_cnt",   32'(cnt), 1);
        btn = 1'b0;
        idle(20);

        // Counter wrap on the narrow instance, plain increment on the wide one.
        do_reset(1'b0);
        idle(5);
        repeat ((1 << CNT_W_S) - 1) press(1'b0);
        check("wrap_pre_w",  32'(cnt_s), (1 << CNT_W_S) - 1);
        check("wrap_pre",    32'(cnt),   (1 << CNT_W_S) - 1);
        press(1'b0);
        check("wrap_post_w", 32'(cnt_s), 0);
        check("wrap_post",   32'(cnt),   1 << CNT_W_S);
        check("wrap_missed", 32'(missed), 1);

        // Randomised bursts of bouncing and clean holds with sporadic acks.
        do_reset(1'b0);
        repeat (150) begin
            int n;
            btn = 1'($urandom_range(0, 1));
            n   = int'($urandom_range(1, 24));
            for (int j = 0; j < n; j++) begin
                ack = ($urandom_range(0, 9) == 0);
                idle(1);
            end
        end
        ack = 1'b0;
        btn = 1'b0;
        idle(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
